mult_nxn_fast: RTL and testbench

MULT_NXN_FAST -- requirements
Module: mult_nxn_fast

---
 rtl/mult_nxn_fast.sv | 167 ++++++++++++++++
 tb/tb_mult_nxn_fast.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mult_nxn_fast.sv
// mult_nxn_fast -- sequential N x N unsigned multiplier built from one W x W
// multiplier and one 2N-bit accumulator.  Each operand is split into K = N/W
// chunks.  Chunks above the highest nonzero chunk of each operand are skipped,
// so an operation takes (ka+1)*(kb+1) accumulate cycles.
//
// Ports
//   clk      : clock, all state on the rising edge
//   reset    : synchronous, active-high; aborts any operation in flight
//   start    : multiply request, only honoured in IDLE
//   a, b     : N-bit unsigned operands, latched when start is accepted
//   busy     : high while accumulating (RUN)
//   done     : one-cycle pulse, product is final
//   product  : registered 2N-bit result, held until the next accepted start
module mult_nxn_fast #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product
);

  localparam int K     = N / W;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam int SH_W  = $clog2(2 * N);

  // Refuse to elaborate with an unusable chunking.
  generate
    if ((N % W) != 0 || (N / W) < 2) begin : g_bad_params
      $error("mult_nxn_fast: N must be a multiple of W with N/W >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [N-1:0]       a_reg, a_next;
  logic [N-1:0]       b_reg, b_next;
  logic [2*N-1:0]     product_reg, product_next;
  logic [IDX_W-1:0]   i_reg, i_next;
  logic [IDX_W-1:0]   j_reg, j_next;
  logic [IDX_W-1:0]   ka_reg, ka_next;
  logic [IDX_W-1:0]   kb_reg, kb_next;

  // Chunk views: latched operands feed the multiplier, raw inputs feed the
  // highest-nonzero-chunk search done at acceptance time.
  logic [W-1:0]       a_chunk [K];
  logic [W-1:0]       b_chunk [K];
  logic [K-1:0]       a_nz;
  logic [K-1:0]       b_nz;

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_chunks
      assign a_chunk[gi] = a_reg[W*gi +: W];
      assign b_chunk[gi] = b_reg[W*gi +: W];
      assign a_nz[gi]    = |a[W*gi +: W];
      assign b_nz[gi]    = |b[W*gi +: W];
    end
  endgenerate

  // Highest nonzero chunk index; 0 when the operand is zero, so a zero
  // operand still gets one chunk pass and accumulates 0.
  logic [IDX_W-1:0] ka_calc, kb_calc;
  always_comb begin
    ka_calc = '0;
    kb_calc = '0;
    for (int c = 0; c < K; c++) begin
      if (a_nz[c]) ka_calc = IDX_W'(c);
      if (b_nz[c]) kb_calc = IDX_W'(c);
    end
  end

  // Single W x W multiplier, result shifted into place at full 2N width.
  logic [W-1:0]     a_sel, b_sel;
  logic [2*W-1:0]   partial;
  logic [SH_W-1:0]  shift_amt;
  logic [2*N-1:0]   term;

  assign a_sel     = a_chunk[i_reg];
  assign b_sel     = b_chunk[j_reg];
  assign partial   = (2*W)'(a_sel) * (2*W)'(b_sel);
  assign shift_amt = SH_W'((int'(i_reg) + int'(j_reg)) * W);
  assign term      = (2*N)'(partial) << shift_amt;

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    product_next = product_reg;
    i_next       = i_reg;
    j_next       = j_reg;
    ka_next      = ka_reg;
    kb_next      = kb_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next       = a;
          b_next       = b;
          product_next = '0;
          ka_next      = ka_calc;
          kb_next      = kb_calc;
          i_next       = '0;
          j_next       = '0;
          state_next   = RUN;
        end
      end
      RUN: begin
        product_next = product_reg + term;
        if (j_reg == kb_reg) begin
          j_next = '0;
          if (i_reg == ka_reg) begin
            state_next = DONE;
          end else begin
            i_next = i_reg + 1'b1;
          end
        end else begin
          j_next = j_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      product_reg <= '0;
      i_reg       <= '0;
      j_reg       <= '0;
      ka_reg      <= '0;
      kb_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      product_reg <= product_next;
      i_reg       <= i_next;
      j_reg       <= j_next;
      ka_reg      <= ka_next;
      kb_reg      <= kb_next;
    end
  end

  // Outputs decode registered state only.
  assign busy    = (state_reg == RUN);
  assign done    = (state_reg == DONE);
  assign product = product_reg;

endmodule

// File: tb/tb_mult_nxn_fast.sv
// Self-checking bench for mult_nxn_fast (N=32, W=8): directed corner cases
// plus randomized sparse operands against an arithmetic reference model.
module tb_mult_nxn_fast;

  localparam int N = 32;
  localparam int W = 8;

  logic            clk;
  logic            reset;
  logic            start;
  logic [N-1:0]    a;
  logic [N-1:0]    b;
  logic            busy;
  logic            done;
  logic [2*N-1:0]  product;

  int checks = 0;
  int errors = 0;

  mult_nxn_fast #(.N(N), .W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: index of highest nonzero byte (0 for zero operand).
  function automatic int top_chunk(input logic [N-1:0] v);
    int k = 0;
    for (int c = 0; c < N / W; c++)
      if (((v >> (W * c)) & 32'hFF) != 0) k = c;
    return k;
  endfunction

  // One operation. inject_cyc >= 0 pulses start (a=b=1) in that RUN cycle
  // (0-based), which must be ignored.
  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input int inject_cyc);
    logic [63:0] exp_p;
    int          exp_cycles;
    int          busy_cnt;
    int          cyc;
    bit          seen;
    exp_p      = 64'(av) * 64'(bv);
    exp_cycles = (top_chunk(av) + 1) * (top_chunk(bv) + 1);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;  // must not disturb the latched operands
    busy_cnt = 0; cyc = 0; seen = 1'b0;
    while (cyc < 64) begin
      if (cyc == inject_cyc) begin
        start = 1'b1; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    check("busy_cycles", 64'(busy_cnt), 64'(exp_cycles));
    check("done_latency", 64'(cyc), 64'(exp_cycles));
    check("product", product, exp_p);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("product_held", product, exp_p);
    $display("op a=0x%08h b=0x%08h P=%0d product=0x%016h", av, bv, exp_cycles, product);
  endtask

  initial begin
    logic [63:0] held;
    int          cnt_done;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    // start during reset must be ignored
    start = 1'b1; a = 32'h5; b = 32'h7;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", product, 64'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);

    run_op(32'h000000FF, 32'h00000002, -1);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    run_op(32'h01000000, 32'h00010000, -1);
    run_op(32'h00000000, 32'hDEADBEEF, -1);
    run_op(32'hDEADBEEF, 32'h00000000, -1);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4);  // ignored start in RUN cycle 5

    // IDLE with start low: product must not move while inputs wiggle.
    held = product;
    for (int k = 0; k < 5; k++) begin
      a = $urandom; b = $urandom;
      @(negedge clk);
    end
    check("idle_hold", product, held);

    // Mid-operation reset in RUN cycle 3.
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_product", product, 64'd0);
    check("abort_done", 64'(done), 64'd0);
    cnt_done = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) cnt_done++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(cnt_done), 64'd0);
    $display("op reset abort checked");
    run_op(32'd3, 32'd5, -1);

    // Randomized sparse operands.
    for (int t = 0; t < 30; t++) begin
      logic [N-1:0] ra, rb;
      ra = $urandom >> (8 * $urandom_range(0, 4));
      rb = $urandom >> (8 * $urandom_range(0, 4));
      run_op(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
